// File: rtl/bram_port_initiator.sv
// bram_port_initiator: valid/ready request/response front end for one port of a
// single-port write-first block RAM, with credit-bounded response buffering.
module bram_port_initiator #(
    parameter int RAM_WIDTH = 18,
    parameter int RAM_DEPTH = 1024,
    parameter RAM_PERFORMANCE = "HIGH_PERFORMANCE",
    parameter int RSP_DEPTH = 4
) (
    input  logic                         clka,
    input  logic                         rsta_n,
    input  logic                         req_valid,
    output logic                         req_ready,
    input  logic                         req_we,
    input  logic [$clog2(RAM_DEPTH)-1:0] req_addr,
    input  logic [RAM_WIDTH-1:0]         req_wdata,
    output logic                         rsp_valid,
    input  logic                         rsp_ready,
    output logic [RAM_WIDTH-1:0]         rsp_rdata,
    output logic [$clog2(RAM_DEPTH)-1:0] ram_addra,
    output logic [RAM_WIDTH-1:0]         ram_dina,
    output logic                         ram_wea,
    output logic                         ram_ena,
    output logic                         ram_regcea,
    output logic                         ram_rsta,
    input  logic [RAM_WIDTH-1:0]         ram_douta
);
    localparam int L = (RAM_PERFORMANCE == "HIGH_PERFORMANCE") ? 2 : 1;
    localparam int CW = $clog2(RSP_DEPTH + 1);
    localparam int PW = RSP_DEPTH > 1 ? $clog2(RSP_DEPTH) : 1;
    localparam logic [CW-1:0] FULL = CW'(RSP_DEPTH);
    localparam logic [PW-1:0] LAST = PW'(RSP_DEPTH - 1);
    logic [CW-1:0] cnt, occ;
    logic [PW-1:0] rd_ptr, wr_ptr;
    logic [L-1:0] pipe;
    logic [RAM_WIDTH-1:0] mem [RSP_DEPTH];
    logic acc, rd_acc, push, pop;
    // credits count reads in flight plus queued entries, so the FIFO never overflows
    assign req_ready = rsta_n && cnt < FULL;
    assign acc = req_valid && req_ready;
    assign rd_acc = acc && !req_we;
    assign push = pipe[L-1];
    assign pop = rsp_valid && rsp_ready;
    assign rsp_valid = occ != '0;
    assign rsp_rdata = rsp_valid ? mem[rd_ptr] : '0;
    assign ram_ena = acc;
    assign ram_wea = acc && req_we;
    assign ram_addra = req_addr;
    assign ram_dina = req_wdata;
    assign ram_regcea = 1'b1;
    assign ram_rsta = !rsta_n;
    always_ff @(posedge clka) begin
        if (!rsta_n) begin
            cnt <= '0;
            occ <= '0;
            rd_ptr <= '0;
            wr_ptr <= '0;
            pipe <= '0;
        end else begin
            cnt <= cnt + CW'(rd_acc) - CW'(pop);
            occ <= occ + CW'(push) - CW'(pop);
            pipe <= L'({pipe, rd_acc});
            if (push) begin
                mem[wr_ptr] <= ram_douta;
                wr_ptr <= wr_ptr == LAST ? '0 : wr_ptr + 1'b1;
            end
            if (pop) rd_ptr <= rd_ptr == LAST ? '0 : rd_ptr + 1'b1;
        end
    end
endmodule

// File: tb/tb_bram_port_initiator.sv
// tb_bram_port_initiator: table, directed and random checks of the RAM port
// front end against a queue-based response model and a behavioural RAM.
module tb_bram_port_initiator;
    typedef struct {
        logic [17:0] d;
        int          due;
    } exp_t;
    typedef struct {
        logic        v, we;
        logic [9:0]  a;
        logic [17:0] d;
        logic        rr, e_rdy, e_val;
        logic [17:0] e_dat;
    } vec_t;

    logic clk = 0;
    always #5 clk = ~clk;

    logic        rst_n, req_valid, req_ready, req_we, rsp_valid, rsp_ready;
    logic [9:0]  req_addr, ram_addra;
    logic [17:0] req_wdata, rsp_rdata, ram_dina, ram_douta, a_raw;
    logic        ram_wea, ram_ena, ram_regcea, ram_rsta;
    logic        b_req_valid, b_req_ready, b_req_we, b_rsp_valid, b_rsp_ready;
    logic [9:0]  b_req_addr, b_ram_addra;
    logic [17:0] b_req_wdata, b_rsp_rdata, b_ram_dina, b_ram_douta;
    logic        b_ram_wea, b_ram_ena, b_ram_regcea, b_ram_rsta;

    bram_port_initiator dut (
        .clka(clk), .rsta_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
        .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .ram_addra(ram_addra), .ram_dina(ram_dina), .ram_wea(ram_wea), .ram_ena(ram_ena),
        .ram_regcea(ram_regcea), .ram_rsta(ram_rsta), .ram_douta(ram_douta)
    );

    bram_port_initiator #(.RAM_PERFORMANCE("LOW_LATENCY"), .RSP_DEPTH(3)) dut_b (
        .clka(clk), .rsta_n(rst_n), .req_valid(b_req_valid), .req_ready(b_req_ready),
        .req_we(b_req_we), .req_addr(b_req_addr), .req_wdata(b_req_wdata),
        .rsp_valid(b_rsp_valid), .rsp_ready(b_rsp_ready), .rsp_rdata(b_rsp_rdata),
        .ram_addra(b_ram_addra), .ram_dina(b_ram_dina), .ram_wea(b_ram_wea), .ram_ena(b_ram_ena),
        .ram_regcea(b_ram_regcea), .ram_rsta(b_ram_rsta), .ram_douta(b_ram_douta)
    );

    // behavioural write-first RAMs: registered output (L=2) and latch-only (L=1)
    logic [17:0] aram [1024];
    logic [17:0] bram [1024];
    always @(posedge clk) begin
        if (ram_ena) begin
            if (ram_wea) aram[ram_addra] <= ram_dina;
            a_raw <= ram_wea ? ram_dina : aram[ram_addra];
        end
        if (ram_rsta) ram_douta <= '0;
        else if (ram_regcea) ram_douta <= a_raw;
    end
    always @(posedge clk) begin
        if (b_ram_ena) begin
            if (b_ram_wea) bram[b_ram_addra] <= b_ram_dina;
            b_ram_douta <= b_ram_wea ? b_ram_dina : bram[b_ram_addra];
        end
    end

    int total = 0, bad = 0, cyc = 0, bc = 0;
    logic prev_rst = 0;
    exp_t qa[$], qb[$];
    logic [17:0] mem_m [1024];
    logic [17:0] bmem_m [8];
    vec_t tbl [18];

    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)", n, act, exp, cyc);
        end
    endtask

    function automatic vec_t mk(input int v, we, a, d, rr, er, ev, ed);
        vec_t t;
        t.v = v[0]; t.we = we[0]; t.a = a[9:0]; t.d = d[17:0]; t.rr = rr[0];
        t.e_rdy = er[0]; t.e_val = ev[0]; t.e_dat = ed[17:0];
        return t;
    endfunction

    // one cycle on the main DUT: drive, compare against the model, advance the model
    task automatic apply(input int rst, v, we, a, d, rr);
        logic e_rdy, e_acc, e_val;
        @(negedge clk);
        rst_n = !rst[0]; req_valid = v[0]; req_we = we[0];
        req_addr = a[9:0]; req_wdata = d[17:0]; rsp_ready = rr[0];
        #1;
        e_rdy = !rst[0] && qa.size() < 4;
        e_acc = v[0] && e_rdy;
        e_val = qa.size() > 0 && qa[0].due <= cyc;
        chk("req_ready", req_ready, e_rdy);
        chk("ram_ena", ram_ena, e_acc);
        chk("ram_wea", ram_wea, e_acc && we[0]);
        chk("ram_rsta", ram_rsta, rst[0]);
        if (e_acc) chk("ram_addra", ram_addra, a[9:0]);
        if (e_acc && we[0]) chk("ram_dina", ram_dina, d[17:0]);
        if (!(rst[0] && !prev_rst)) begin
            chk("rsp_valid", rsp_valid, e_val);
            if (e_val) chk("rsp_rdata", rsp_rdata, qa[0].d);
            else if (rst[0]) chk("rsp_rdata_rst", rsp_rdata, 0);
        end
        if (rst[0]) qa.delete();
        else begin
            if (e_val && rr[0]) void'(qa.pop_front());
            if (e_acc && we[0]) mem_m[a[9:0]] = d[17:0];
            else if (e_acc) qa.push_back('{mem_m[a[9:0]], cyc + 3});
        end
        prev_rst = rst[0];
        cyc++;
    endtask

    // one cycle on the LOW_LATENCY DUT with the consumer always ready
    task automatic b_cycle(input int v, we, a, d);
        logic e_val;
        @(negedge clk);
        b_req_valid = v[0]; b_req_we = we[0]; b_req_addr = a[9:0]; b_req_wdata = d[17:0];
        #1;
        e_val = qb.size() > 0 && qb[0].due <= bc;
        chk("b_req_ready", b_req_ready, 1);
        chk("b_rsp_valid", b_rsp_valid, e_val);
        if (e_val) begin
            chk("b_rsp_rdata", b_rsp_rdata, qb[0].d);
            void'(qb.pop_front());
        end
        if (v[0] && we[0]) bmem_m[a[2:0]] = d[17:0];
        else if (v[0]) qb.push_back('{bmem_m[a[2:0]], bc + 2});
        bc++;
    endtask

    initial begin
        int acc_n, bias;
        rst_n = 0; req_valid = 0; req_we = 0; req_addr = '0; req_wdata = '0; rsp_ready = 0;
        b_req_valid = 0; b_req_we = 0; b_req_addr = '0; b_req_wdata = '0; b_rsp_ready = 1;
        tbl[0] = mk(1, 1, 0, 'h11, 1, 1, 0, 0);
        tbl[1] = mk(1, 1, 1, 'h12, 1, 1, 0, 0);
        tbl[2] = mk(1, 1, 2, 'h13, 1, 1, 0, 0);
        tbl[3] = mk(1, 1, 3, 'h14, 1, 1, 0, 0);
        tbl[4] = mk(1, 0, 0, 0, 1, 1, 0, 0);
        tbl[5] = mk(1, 0, 1, 0, 1, 1, 0, 0);
        tbl[6] = mk(1, 0, 2, 0, 1, 1, 0, 0);
        tbl[7] = mk(1, 0, 3, 0, 1, 1, 1, 'h11);
        tbl[8] = mk(0, 0, 0, 0, 1, 1, 1, 'h12);
        tbl[9] = mk(0, 0, 0, 0, 1, 1, 1, 'h13);
        tbl[10] = mk(0, 0, 0, 0, 1, 1, 1, 'h14);
        tbl[11] = mk(0, 0, 0, 0, 1, 1, 0, 0);
        tbl[12] = mk(1, 1, 5, 'h2AAAA, 1, 1, 0, 0);
        tbl[13] = mk(1, 0, 5, 0, 1, 1, 0, 0);
        tbl[14] = mk(0, 0, 0, 0, 1, 1, 0, 0);
        tbl[15] = mk(0, 0, 0, 0, 1, 1, 0, 0);
        tbl[16] = mk(0, 0, 0, 0, 1, 1, 1, 'h2AAAA);
        tbl[17] = mk(0, 0, 0, 0, 1, 1, 0, 0);

        apply(1, 0, 0, 0, 0, 0);
        apply(1, 0, 0, 0, 0, 0);
        chk("regcea", ram_regcea, 1);
        chk("b_reset_valid", b_rsp_valid, 0);
        chk("b_reset_ready", b_req_ready, 0);

        foreach (tbl[i]) begin
            apply(0, tbl[i].v, tbl[i].we, tbl[i].a, tbl[i].d, tbl[i].rr);
            chk("tbl_ready", req_ready, tbl[i].e_rdy);
            chk("tbl_valid", rsp_valid, tbl[i].e_val);
            if (tbl[i].e_val) chk("tbl_rdata", rsp_rdata, tbl[i].e_dat);
        end

        // backpressure: only four reads fit, one pop frees a credit next cycle
        acc_n = 0;
        for (int i = 0; i < 10; i++) begin
            apply(0, 1, 0, i % 4, 0, 0);
            acc_n += int'(ram_ena);
        end
        chk("bp_accepted", acc_n, 4);
        chk("bp_stalled", req_ready, 0);
        apply(0, 1, 0, 2, 0, 1);
        chk("bp_pop_same_cycle_ready", req_ready, 0);
        apply(0, 1, 0, 3, 0, 0);
        chk("bp_credit_back", req_ready, 1);
        for (int i = 0; i < 8; i++) apply(0, 0, 0, 0, 0, 1);

        // pop and push in the same cycle with all credits taken
        for (int i = 0; i < 4; i++) apply(0, 1, 0, 3 - i, 0, 0);
        apply(0, 0, 0, 0, 0, 0);
        apply(0, 0, 0, 0, 0, 1);
        apply(0, 0, 0, 0, 0, 0);
        chk("pp_valid", rsp_valid, 1);
        chk("pp_ready", req_ready, 1);
        for (int i = 0; i < 6; i++) apply(0, 0, 0, 0, 0, 1);

        // reset with two reads in flight and two queued
        for (int i = 0; i < 4; i++) apply(0, 1, 0, i, 0, 0);
        apply(1, 0, 0, 0, 0, 0);
        chk("mid_rst_ready", req_ready, 0);
        for (int i = 0; i < 4; i++) begin
            apply(0, 0, 0, 0, 0, 1);
            chk("mid_rst_no_rsp", rsp_valid, 0);
            if (i == 0) chk("mid_rst_ready_after", req_ready, 1);
        end

        for (int i = 0; i < 8; i++) apply(0, 1, 1, i, (i * 4099 + 77) & 'h3FFFF, 1);
        for (int s = 0; s < 6; s++) begin
            bias = s % 3 == 0 ? 20 : s % 3 == 1 ? 60 : 95;
            for (int i = 0; i < 100; i++)
                apply($urandom_range(0, 99) == 0, $urandom_range(0, 3) != 0,
                      $urandom_range(0, 3) == 0, $urandom_range(0, 7),
                      $urandom_range(0, 'h3FFFF), $urandom_range(0, 99) < bias);
        end
        for (int i = 0; i < 8; i++) apply(0, 0, 0, 0, 0, 1);
        chk("a_drained", qa.size(), 0);

        for (int i = 0; i < 8; i++) b_cycle(1, 1, i, (i * 5021 + 3) & 'h3FFFF);
        b_cycle(1, 0, 3, 0);
        b_cycle(0, 0, 0, 0);
        chk("b_lat_T1", b_rsp_valid, 0);
        b_cycle(0, 0, 0, 0);
        chk("b_lat_T2", b_rsp_valid, 1);
        b_cycle(0, 0, 0, 0);
        for (int i = 0; i < 24; i++) b_cycle(1, 0, (i * 3) % 8, 0);
        for (int i = 0; i < 4; i++) b_cycle(0, 0, 0, 0);
        chk("b_drained", qb.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
